// File: rtl/dice_roll_reader.sv
// Watches the dice button and face value, waits for the roll to settle, then
// presents the captured face on a valid/ready handshake with an LED decode and a roll tally.
module dice_roll_reader #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [2:0]       throw,
  input  logic             roll_ready,
  output logic             roll_valid,
  output logic [2:0]       roll_value,
  output logic             roll_err,
  output logic             rolling,
  output logic [6:0]       pips,
  output logic [CNT_W-1:0] roll_count
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ROLLING = 2'd1;
  localparam logic [1:0] SETTLE  = 2'd2;
  localparam logic [1:0] PRESENT = 2'd3;

  logic [1:0]    state;
  logic [1:0]    sync_pipe;
  logic [CW-1:0] cnt;
  logic          btn_s;

  assign btn_s = sync_pipe[1];

  // Face layout, bit6..bit0 = BR BL MR ML TR TL centre.
  function automatic logic [6:0] decode(input logic [2:0] face);
    case (face)
      3'd1:    decode = 7'b0000001;
      3'd2:    decode = 7'b1000010;
      3'd3:    decode = 7'b1000011;
      3'd4:    decode = 7'b1100110;
      3'd5:    decode = 7'b1100111;
      3'd6:    decode = 7'b1111110;
      default: decode = 7'b0000000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sync_pipe  <= '0;
      cnt        <= '0;
      roll_valid <= 1'b0;
      roll_value <= '0;
      roll_err   <= 1'b0;
      rolling    <= 1'b0;
      pips       <= '0;
      roll_count <= '0;
    end else begin
      sync_pipe <= {sync_pipe[0], button};
      case (state)
        IDLE: begin
          if (btn_s) begin
            state   <= ROLLING;
            rolling <= 1'b1;
          end
        end
        ROLLING: begin
          if (!btn_s) begin
            state <= SETTLE;
            cnt   <= LOAD;
          end
        end
        SETTLE: begin
          if (btn_s) begin
            state <= ROLLING;
          end else if (cnt == '0) begin
            state      <= PRESENT;
            roll_value <= throw;
            roll_err   <= (throw == 3'd0) || (throw == 3'd7);
            roll_valid <= 1'b1;
            rolling    <= 1'b0;
            pips       <= decode(throw);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        PRESENT: begin
          // Button activity is ignored until the consumer takes the roll.
          if (roll_ready) begin
            state      <= IDLE;
            roll_valid <= 1'b0;
            if (!roll_err && (roll_count != '1))
              roll_count <= roll_count + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
